// File: rtl/imm_pkg.sv
// Shared format-select encodings and result-buffer depth for the immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    SEL_I = 3'b000,
    SEL_S = 3'b001,
    SEL_B = 3'b010,
    SEL_U = 3'b011,
    SEL_J = 3'b100
  } sel_e;

  localparam int DEPTH = 2;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate extraction; every format sign-extends from instr[31].
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  logic [31:0] raw;

  // Each format is first assembled as a 32-bit signed value, then widened to XLEN.
  always_comb begin
    raw = '0;
    err = 1'b0;
    case (sel)
      SEL_I:   raw = {{20{instr[31]}}, instr[31:20]};
      SEL_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      SEL_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      SEL_U:   raw = {instr[31:12], 12'b0};
      SEL_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: err = 1'b1;
    endcase
  end

  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 2-entry valid/ready result buffer (head/tail registers).
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic            out_err
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [XLEN-1:0] dec_imm;
  logic            dec_err;
  logic [1:0]      count;
  logic [XLEN-1:0] head_imm, tail_imm;
  logic            head_err, tail_err;
  logic [31:0]     accept_cnt;
  logic            push, pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr (instr),
    .sel   (sel),
    .imm   (dec_imm),
    .err   (dec_err)
  );

  assign in_ready  = (count != FULL);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_imm   = head_imm;
  assign out_err   = head_err;

  // Head register always holds the oldest entry, so it keeps its last value once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= 2'd0;
      head_imm   <= '0;
      head_err   <= 1'b0;
      tail_imm   <= '0;
      tail_err   <= 1'b0;
      accept_cnt <= 32'd0;
    end else begin
      if (push && !pop) begin
        count <= count + 2'd1;
        if (count == 2'd0) begin
          head_imm <= dec_imm;
          head_err <= dec_err;
        end else begin
          tail_imm <= dec_imm;
          tail_err <= dec_err;
        end
      end else if (pop && !push) begin
        count <= count - 2'd1;
        if (count == FULL) begin
          head_imm <= tail_imm;
          head_err <= tail_err;
        end
      end else if (push && pop) begin
        // Only reachable at count 1: the new entry replaces the departing head.
        head_imm <= dec_imm;
        head_err <= dec_err;
      end
      if (push) begin
        accept_cnt <= accept_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench driving XLEN=32 and XLEN=64 instances with identical stimulus.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  sel;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;

  exp_t q32[$];
  exp_t q64[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .sel(sel), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_err(out_err32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .sel(sel), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_err(out_err64)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Drives one entry until both instances accept it; expected values are hand-computed 64-bit.
  task automatic applyStimulus(input logic [31:0] i, input logic [2:0] s, input logic [63:0] e_imm, input logic e_err);
    exp_t e;
    logic ok;
    ok       = 1'b0;
    instr    = i;
    sel      = s;
    in_valid = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready32 && in_ready64;
      if (ok) begin
        e.imm = e_imm;
        e.err = e_err;
        q64.push_back(e);
        e.imm = {32'b0, e_imm[31:0]};
        q32.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks_total++;
      $display("[TB] FAIL accept_timeout: instr 0x%08h never accepted, expected acceptance within 20 cycles", i);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid32 && out_ready) begin
      if (q32.size() == 0) begin
        checks_total++;
        $display("[TB] FAIL d32_unexpected: got imm 0x%08h, expected no output", out_imm32);
      end else begin
        exp_t e;
        e = q32.pop_front();
        checkOutput("d32_imm", {32'b0, out_imm32}, e.imm);
        checkOutput("d32_err", {63'b0, out_err32}, {63'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid64 && out_ready) begin
      if (q64.size() == 0) begin
        checks_total++;
        $display("[TB] FAIL d64_unexpected: got imm 0x%016h, expected no output", out_imm64);
      end else begin
        exp_t e;
        e = q64.pop_front();
        checkOutput("d64_imm", out_imm64, e.imm);
        checkOutput("d64_err", {63'b0, out_err64}, {63'b0, e.err});
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    instr     = 32'h0;
    sel       = 3'b000;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_out_valid32", {63'b0, out_valid32}, 64'd0);
    checkOutput("rst_out_valid64", {63'b0, out_valid64}, 64'd0);
    checkOutput("rst_in_ready32", {63'b0, in_ready32}, 64'd1);
    checkOutput("rst_out_imm64", out_imm64, 64'd0);
    checkOutput("rst_out_err32", {63'b0, out_err32}, 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] basic formats, out_ready=1");
    out_ready = 1'b1;
    applyStimulus(32'hFFF00093, 3'b000, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    checkOutput("latency_valid32", {63'b0, out_valid32}, 64'd1);
    checkOutput("latency_imm32", {32'b0, out_imm32}, 64'hFFFFFFFF);
    applyStimulus(32'h00A00223, 3'b001, 64'h0000000000000004, 1'b0);
    applyStimulus(32'h00208263, 3'b010, 64'h0000000000000004, 1'b0);
    applyStimulus(32'h123450B7, 3'b011, 64'h0000000012345000, 1'b0);
    applyStimulus(32'hFFDFF06F, 3'b100, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    applyStimulus(32'h00700093, 3'b111, 64'h0, 1'b1);
    applyStimulus(32'hFFFFFFFF, 3'b101, 64'h0, 1'b1);
    applyStimulus(32'h00700093, 3'b000, 64'h0000000000000007, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("drained_valid32", {63'b0, out_valid32}, 64'd0);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(32'h00100093, 3'b000, 64'h0000000000000001, 1'b0);
    applyStimulus(32'hABCDE037, 3'b011, 64'hFFFFFFFFABCDE000, 1'b0);
    fork
      applyStimulus(32'h80000063, 3'b010, 64'hFFFFFFFFFFFFF000, 1'b0);
      begin
        repeat (2) begin
          @(negedge clk);
          checkOutput("full_in_ready32", {63'b0, in_ready32}, 64'd0);
          checkOutput("stall_imm32", {32'b0, out_imm32}, 64'h1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] reset with two entries buffered");
    out_ready = 1'b0;
    applyStimulus(32'h00500093, 3'b000, 64'h5, 1'b0);
    applyStimulus(32'h00600093, 3'b000, 64'h6, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q32.delete();
    q64.delete();
    @(negedge clk);
    checkOutput("midrst_valid32", {63'b0, out_valid32}, 64'd0);
    checkOutput("midrst_valid64", {63'b0, out_valid64}, 64'd0);
    checkOutput("midrst_in_ready32", {63'b0, in_ready32}, 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(32'h00200093, 3'b000, 64'h2, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    checkOutput("q32_empty", 64'(q32.size()), 64'd0);
    checkOutput("q64_empty", 64'(q64.size()), 64'd0);

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
